// File: rtl/irq_pkg.sv
// Shared constants, state encoding and cause construction for the machine-mode
// interrupt controller.
package irq_pkg;

  localparam int MSI_BIT = 3;
  localparam int MTI_BIT = 7;
  localparam int MEI_BIT = 11;

  localparam logic [3:0] MSI_CODE = 4'd3;
  localparam logic [3:0] MTI_CODE = 4'd7;
  localparam logic [3:0] MEI_CODE = 4'd11;

  // Widest XLEN the cause helper supports; callers cast down to their XLEN.
  localparam int MAX_XLEN = 64;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACTIVE
  } irq_state_t;

  // Compact view of the three architectural interrupt bits.
  typedef struct packed {
    logic mei;
    logic msi;
    logic mti;
  } irq_vec_t;

  // Interrupt flag in bit xlen-1, exception code in the low nibble.
  function automatic logic [MAX_XLEN-1:0] irq_cause(input int unsigned xlen,
                                                    input logic [3:0] code);
    return (MAX_XLEN'(1) << (xlen - 1)) | MAX_XLEN'(code);
  endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder for pending-and-enabled interrupts:
// MEI > MSI > MTI.
module irq_priority_enc
  import irq_pkg::*;
(
  input  irq_vec_t   pe,
  output logic       any,
  output logic [3:0] code
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if-chain can leave it unassigned and infer a latch.
  always_comb begin
    any  = |pe;
    code = '0;
    if (pe.mei)      code = MEI_CODE;
    else if (pe.msi) code = MSI_CODE;
    else if (pe.mti) code = MTI_CODE;
  end

endmodule

// File: rtl/machine_irq_ctrl.sv
// Machine-mode interrupt controller: holds mip/mie, raises a sticky trap
// request for the highest-priority enabled source and tracks the handler.
module machine_irq_ctrl
  import irq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mtip,
  input  logic            msip,
  input  logic            meip,
  input  logic            mstatus_mie,
  input  logic            mie_wr,
  input  logic [XLEN-1:0] mie_wdata,
  input  logic            trap_ack,
  input  logic            mret,
  output logic [XLEN-1:0] mip,
  output logic [XLEN-1:0] mie,
  output logic            trap_req,
  output logic [XLEN-1:0] trap_cause,
  output logic            irq_active
);

  irq_vec_t        mip_q;
  irq_vec_t        mie_q;
  irq_vec_t        pe;
  irq_state_t      state_q;
  irq_state_t      state_d;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] cause_d;
  logic [XLEN-1:0] new_cause;
  logic            pe_any;
  logic [3:0]      pe_code;

  // Only bits 3, 7 and 11 of the write data are architectural.
  logic unused_wdata;
  assign unused_wdata = ^{mie_wdata[XLEN-1:12], mie_wdata[10:8],
                          mie_wdata[6:4], mie_wdata[2:0]};

  assign pe = irq_vec_t'(mip_q & mie_q);

  irq_priority_enc u_prio (
    .pe   (pe),
    .any  (pe_any),
    .code (pe_code)
  );

  assign new_cause = XLEN'(irq_cause(XLEN, pe_code));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      mip_q   <= '0;
      mie_q   <= '0;
      state_q <= IDLE;
      cause_q <= '0;
    end else begin
      mip_q <= '{mei: meip, msi: msip, mti: mtip};
      if (mie_wr) begin
        mie_q <= '{mei: mie_wdata[MEI_BIT],
                   msi: mie_wdata[MSI_BIT],
                   mti: mie_wdata[MTI_BIT]};
      end
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // The cause is captured once on entry to REQ and held through ACTIVE, so
  // later source changes never disturb an outstanding or running trap.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: begin
        if (mstatus_mie && pe_any) begin
          state_d = REQ;
          cause_d = new_cause;
        end
      end
      REQ: begin
        if (trap_ack) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (mret) begin
          state_d = IDLE;
          cause_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cause_d = '0;
      end
    endcase
  end

  always_comb begin
    mip          = '0;
    mip[MSI_BIT] = mip_q.msi;
    mip[MTI_BIT] = mip_q.mti;
    mip[MEI_BIT] = mip_q.mei;
    mie          = '0;
    mie[MSI_BIT] = mie_q.msi;
    mie[MTI_BIT] = mie_q.mti;
    mie[MEI_BIT] = mie_q.mei;
  end

  assign trap_req   = (state_q == REQ);
  assign irq_active = (state_q == ACTIVE);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_machine_irq_ctrl.sv
// Directed test-plan sequences followed by randomized traffic, all checked
// cycle by cycle against a behavioural model of the interrupt controller.
module tb_machine_irq_ctrl;

  localparam int XLEN = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        mtip, msip, meip, mstatus_mie, mie_wr, trap_ack, mret;
  logic [31:0] mie_wdata;
  logic [31:0] mip, mie, trap_cause;
  logic        trap_req, irq_active;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: architectural mip/mie words, a "trap outstanding" flag, a
  // "handler running" flag and the cause reported to the core.
  logic [31:0] e_mip, e_mie, e_cause;
  bit          e_pending, e_in_handler;

  always #5 clock = ~clock;

  machine_irq_ctrl #(.XLEN(XLEN)) dut (
    .clock       (clock),
    .reset       (reset),
    .mtip        (mtip),
    .msip        (msip),
    .meip        (meip),
    .mstatus_mie (mstatus_mie),
    .mie_wr      (mie_wr),
    .mie_wdata   (mie_wdata),
    .trap_ack    (trap_ack),
    .mret        (mret),
    .mip         (mip),
    .mie         (mie),
    .trap_req    (trap_req),
    .trap_cause  (trap_cause),
    .irq_active  (irq_active)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int          prio[3] = '{11, 3, 7};
    logic [31:0] pend_en;
    if (reset) begin
      e_mip = 0; e_mie = 0; e_cause = 0;
      e_pending = 0; e_in_handler = 0;
      return;
    end
    pend_en = e_mip & e_mie;
    if (!e_pending && !e_in_handler) begin
      if (mstatus_mie && pend_en != 0) begin
        foreach (prio[i]) begin
          if (pend_en[prio[i]]) begin
            e_cause = 32'h8000_0000 + prio[i];
            break;
          end
        end
        e_pending = 1;
      end
    end else if (e_pending) begin
      if (trap_ack) begin
        e_pending = 0;
        e_in_handler = 1;
      end
    end else if (mret) begin
      e_in_handler = 0;
      e_cause = 0;
    end
    e_mip = (32'(msip) << 3) | (32'(mtip) << 7) | (32'(meip) << 11);
    if (mie_wr) e_mie = mie_wdata & 32'h0000_0888;
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      model_edge();
      @(posedge clock);
      #1;
      check("mip", mip, e_mip);
      check("mie", mie, e_mie);
      check("trap_req", 32'(trap_req), 32'(e_pending));
      check("irq_active", 32'(irq_active), 32'(e_in_handler));
      check("trap_cause", trap_cause, e_cause);
    end
  endtask

  task automatic write_mie(input logic [31:0] val);
    mie_wr = 1; mie_wdata = val;
    step();
    mie_wr = 0; mie_wdata = 0;
  endtask

  task automatic pulse_ack();
    trap_ack = 1; step(); trap_ack = 0;
  endtask

  task automatic pulse_mret();
    mret = 1; step(); mret = 0;
  endtask

  initial begin
    reset = 1; mtip = 0; msip = 0; meip = 0; mstatus_mie = 0;
    mie_wr = 0; mie_wdata = 0; trap_ack = 0; mret = 0;
    e_mip = 'x; e_mie = 'x; e_cause = 'x; e_pending = 0; e_in_handler = 0;
    @(posedge clock); #1;
    step(2);
    check("rst_mip", mip, 0);
    check("rst_trap_cause", trap_cause, 0);
    check("rst_trap_req", 32'(trap_req), 0);
    reset = 0;

    // Timer only: mip one edge after the line, request one edge later.
    mstatus_mie = 1;
    write_mie(32'h80);
    mtip = 1;
    step();
    check("t1_mip", mip, 32'h80);
    check("t1_req_early", 32'(trap_req), 0);
    step();
    check("t1_req", 32'(trap_req), 1);
    check("t1_cause", trap_cause, 32'h8000_0007);

    // Sticky request while the source and global enable drop.
    mtip = 0; mstatus_mie = 0;
    step(5);
    check("sticky_req", 32'(trap_req), 1);
    check("sticky_cause", trap_cause, 32'h8000_0007);
    pulse_ack();
    check("ack_active", 32'(irq_active), 1);
    check("ack_req", 32'(trap_req), 0);
    pulse_mret();
    check("mret_idle", 32'(irq_active), 0);

    // All sources: MEI wins, then MSI after the handler returns.
    mstatus_mie = 1; msip = 1; mtip = 1; meip = 1;
    write_mie(32'h888);
    step();
    check("all_cause", trap_cause, 32'h8000_000B);
    meip = 0;
    pulse_ack();
    pulse_mret();
    step();
    check("next_cause", trap_cause, 32'h8000_0003);

    // New sources ignored in ACTIVE; re-request one edge after mret.
    pulse_ack();
    meip = 1;
    step(3);
    check("active_no_req", 32'(trap_req), 0);
    pulse_mret();
    check("mret_no_req", 32'(trap_req), 0);
    step();
    check("rereq_cause", trap_cause, 32'h8000_000B);

    // Reset in REQ, then in ACTIVE, with sources held high.
    reset = 1; step(); reset = 0;
    check("rst_req_out", {trap_req, irq_active, mie[11:0], trap_cause[3:0]}, 0);
    step(3);
    check("rst_mie0_noreq", 32'(trap_req), 0);
    write_mie(32'h888);
    step();
    pulse_ack();
    check("pre_rst_active", 32'(irq_active), 1);
    reset = 1; step(); reset = 0;
    check("rst_act_out", 32'(irq_active), 0);
    check("rst_act_cause", trap_cause, 0);

    // Write mask, stray ack in IDLE, stray mret in REQ, ack+mret together.
    meip = 0; msip = 0; mtip = 0; mstatus_mie = 0;
    write_mie(32'hFFFF_FFFF);
    check("mie_mask", mie, 32'h0000_0888);
    pulse_ack();
    check("idle_ack", 32'(irq_active), 0);
    mstatus_mie = 1; mtip = 1;
    step(2);
    pulse_mret();
    check("req_mret", 32'(trap_req), 1);
    trap_ack = 1; mret = 1; step(); trap_ack = 0; mret = 0;
    check("ack_mret_same", 32'(irq_active), 1);
    pulse_mret();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(199) == 0);
      mtip        = ($urandom_range(3) != 0);
      msip        = ($urandom_range(3) == 0);
      meip        = ($urandom_range(4) == 0);
      mstatus_mie = ($urandom_range(5) != 0);
      mie_wr      = ($urandom_range(15) == 0);
      mie_wdata   = $urandom();
      trap_ack    = ($urandom_range(3) == 0);
      mret        = ($urandom_range(4) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/machine_irq_ctrl.md
# machine_irq_ctrl

Machine-mode interrupt controller that consumes the timer interrupt line `mtip`, together with the software (`msip`) and external (`meip`) interrupt lines. It holds the architectural `mip` and `mie` state. It prioritises pending and enabled sources, then raises a trap request to the core pipeline using a request/acknowledge handshake. It also tracks handler occupancy until `mret`. It sits between the timer block and the core's trap/CSR logic.

## Interface
- `XLEN`, default 32: data width of the CSR and cause buses.
- `clock` in, 1 bit: rising-edge clock.
- `reset` in, 1 bit: synchronous, active-high.
- `mtip` in, 1 bit: timer interrupt pending, level.
- `msip` in, 1 bit: software interrupt pending, level.
- `meip` in, 1 bit: external interrupt pending, level.
- `mstatus_mie` in, 1 bit: global machine interrupt enable.
- `mie_wr` in, 1 bit: write strobe for the `mie` register.
- `mie_wdata` in, XLEN bits: write data for `mie`.
- `trap_ack` in, 1 bit: core has accepted the trap.
- `mret` in, 1 bit: core is retiring an `mret`.
- `mip` out, XLEN bits: registered pending bits; only bits 3, 7 and 11 are non-zero.
- `mie` out, XLEN bits: enable register; only bits 3, 7 and 11 are writable.
- `trap_req` out, 1 bit: interrupt trap request.
- `trap_cause` out, XLEN bits: mcause value; valid while `trap_req` is high.
- `irq_active` out, 1 bit: a handler is in progress.

## Operation
- `mip` register:
  - bit 3 is sampled from `msip`, bit 7 from `mtip`, bit 11 from `meip`, every cycle.
  - All other bits read 0.
  - `mip` is not software-writable.
- `mie` register:
  - When `mie_wr` is high, bits 3, 7 and 11 load from `mie_wdata`.
  - All other bits stay 0.
- Pending-enabled vector: `pe = mip & mie`.
- Priority is fixed: MEI (11) > MSI (3) > MTI (7).
- Cause value is `{1'b1, (XLEN-5)'b0, code[3:0]}`, where code is 11, 3 or 7.
- FSM states:
  - IDLE: `trap_req` = 0, `irq_active` = 0.
  - REQ: `trap_req` = 1, `trap_cause` = latched cause.
  - ACTIVE: `irq_active` = 1.
- IDLE → REQ when `mstatus_mie` is high and `pe` is non-zero. The highest-priority cause is latched on this transition.
- REQ → ACTIVE on `trap_ack`.
- REQ is sticky:
  - Deassertion of the source, `mstatus_mie` or the `mie` bit does not withdraw the request.
  - `trap_cause` stays constant until acknowledged.
  - A higher-priority source arriving during REQ does not replace the latched cause.
- ACTIVE → IDLE on `mret`. New pending sources are ignored while ACTIVE.
- Ignored inputs:
  - `trap_ack` outside REQ.
  - `mret` outside ACTIVE.
- If `trap_ack` and `mret` are high in the same cycle in REQ, only the ack is acted on.
- `trap_cause` reads 0 in IDLE. It holds its last value in ACTIVE.

## Timing
- Reset values: `mip`, `mie`, `trap_req`, `trap_cause` and `irq_active` are all 0; FSM goes to IDLE. Reset in any state returns to IDLE at the next edge and drops any outstanding request.
- Source to `mip` latency is 1 cycle: a line high at edge k gives `mip` bit = 1 after edge k.
- `mip` to request latency is 1 cycle: `trap_req` = 1 after edge k+1, given that `mie` and `mstatus_mie` are set.
- `mie` writes take effect after the write edge. A request can follow at the next edge.
- Handshake:
  - The transfer occurs on an edge with `trap_req` && `trap_ack` high.
  - `trap_req` is 0 and `irq_active` is 1 after that edge.
  - `trap_ack` is not required to be held.
- After the `mret` edge the FSM is in IDLE. The earliest re-request is `trap_req` = 1 one edge later, if a source is still pending.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `irq_pkg`:
  - bit-index constants `MSI_BIT`=3, `MTI_BIT`=7, `MEI_BIT`=11;
  - cause-code constants;
  - FSM state enum `irq_state_t` (IDLE, REQ, ACTIVE);
  - a function that builds the XLEN-wide interrupt cause.
- Sub-module `irq_priority_enc`: combinational. Takes `pe` and outputs `any` plus a 4-bit `code` using the fixed priority.

## Test plan
- Reset, then `mie` = 0x80, `mstatus_mie` = 1, `mtip` high at edge 10:
  - `mip` = 0x80 after edge 10;
  - `trap_req` = 1 with `trap_cause` = 0x80000007 after edge 11.
- All three sources high, `mie` = 0x888: `trap_cause` = 0x8000000B. After ack and `mret`, with only `msip` and `mtip` still high, the next cause = 0x80000003.
- In REQ, drop `mtip` and `mstatus_mie` for 5 cycles before acking: `trap_req` stays 1, cause stays 0x80000007, and the ack moves the FSM to ACTIVE.
- In ACTIVE, raise `meip`: no `trap_req` until `mret`. `trap_req` = 1 with cause 0x8000000B one edge after the `mret` edge.
- Assert `reset` while in REQ and separately while in ACTIVE: after the reset edge all outputs are 0. With sources held high and `mie` reset to 0, no request is made.
- `mie_wr` with `mie_wdata` = 0xFFFFFFFF: `mie` reads 0x00000888. `trap_ack` in IDLE and `mret` in REQ cause no state change.
